// File: rtl/vga_pattern_sched_if.sv
// Signal bundle between the VGA timing/pattern block and the connector side.
// The master drives sync, coordinates and colour; the slave drives the pattern controls.
interface vga_pattern_sched_if;
    logic       pause;
    logic       next_req;
    logic       hsync;
    logic       vsync;
    logic       disp_R;
    logic       disp_G;
    logic       disp_B;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic [1:0] pattern;

    modport master (
        input  pause, next_req,
        output hsync, vsync, disp_R, disp_G, disp_B, video_on,
               pixel_x, pixel_y, frame_start, pattern
    );

    modport slave (
        output pause, next_req,
        input  hsync, vsync, disp_R, disp_G, disp_B, video_on,
               pixel_x, pixel_y, frame_start, pattern
    );
endinterface

// File: rtl/vga_pattern_sched.sv
// 640x480@60 VGA timing generator with a four-pattern scheduler, run from the 50 MHz board clock.
// All outputs are registered and lag the raster counters by one clock.
module vga_pattern_sched #(
    parameter int CLK_DIV            = 2,
    parameter int H_ACTIVE           = 640,
    parameter int H_FP               = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BP               = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FP               = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BP               = 33,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic                clock,
    input  logic                rst_n,
    vga_pattern_sched_if.master vga
);
    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_WHITE   = 2'd2,
        PAT_BORDER  = 2'd3
    } pattern_e;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW      = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]    H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]    HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_nxt;
    logic          pending;
    logic          pending_nxt;
    pattern_e      pattern;
    pattern_e      pattern_nxt;

    logic          pix_en;
    logic          h_wrap;
    logic          fe;
    logic          active;
    logic [2:0]    bar;
    logic [2:0]    rgb_c;

    logic          hsync_q;
    logic          vsync_q;
    logic          video_on_q;
    logic [9:0]    pixel_x_q;
    logic [9:0]    pixel_y_q;
    logic [2:0]    rgb_q;
    logic          frame_start_q;

    assign pix_en = (div_cnt == DIV_LAST);
    assign h_wrap = pix_en && (h_cnt == H_LAST);
    assign fe     = h_wrap && (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            if (pix_en) h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        bar   = 3'd7;
        rgb_c = 3'b000;
        // Descending comparator chain: the smallest boundary above h_cnt wins.
        for (int i = 7; i >= 1; i--) begin
            if (h_cnt < 10'(i * BAR_W)) bar = 3'(i - 1);
        end
        case (pattern)
            PAT_BARS:    rgb_c = bar;
            PAT_CHECKER: rgb_c = {3{h_cnt[5] ^ v_cnt[5]}};
            PAT_WHITE:   rgb_c = 3'b111;
            PAT_BORDER:  rgb_c = (h_cnt == '0 || h_cnt == H_ACT_LAST ||
                                  v_cnt == '0 || v_cnt == V_ACT_LAST) ? 3'b111 : 3'b000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            rgb_q         <= 3'b000;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= !(h_cnt >= HS_FIRST && h_cnt <= HS_LAST);
            vsync_q       <= !(v_cnt >= VS_FIRST && v_cnt <= VS_LAST);
            video_on_q    <= active;
            pixel_x_q     <= active ? h_cnt : '0;
            pixel_y_q     <= active ? v_cnt : '0;
            rgb_q         <= active ? rgb_c : 3'b000;
            frame_start_q <= fe;
        end
    end

    // A request arriving on the frame-end clock is honoured at that same boundary.
    always_comb begin
        pattern_nxt   = pattern;
        frame_cnt_nxt = frame_cnt;
        pending_nxt   = pending | vga.next_req;
        if (fe) begin
            if (pending || vga.next_req) begin
                pattern_nxt   = pattern_e'(pattern + 2'd1);
                frame_cnt_nxt = '0;
                pending_nxt   = 1'b0;
            end else if (!vga.pause && frame_cnt == FRAME_LAST) begin
                pattern_nxt   = pattern_e'(pattern + 2'd1);
                frame_cnt_nxt = '0;
            end else if (!vga.pause) begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pattern   <= PAT_BARS;
            frame_cnt <= '0;
            pending   <= 1'b0;
        end else begin
            pattern   <= pattern_nxt;
            frame_cnt <= frame_cnt_nxt;
            pending   <= pending_nxt;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = pixel_x_q;
    assign vga.pixel_y     = pixel_y_q;
    assign vga.disp_R      = rgb_q[2];
    assign vga.disp_G      = rgb_q[1];
    assign vga.disp_B      = rgb_q[0];
    assign vga.frame_start = frame_start_q;
    assign vga.pattern     = pattern;
endmodule
